// File: rtl/if_fetch_unit_if.sv
// Signal bundle between the fetch stage, instruction memory, hazard unit and decode.
// The fetch unit takes the slave modport; its environment takes the master modport.
interface if_fetch_unit_if;
   logic        stall_i;
   logic        redirect_i;
   logic [31:0] redirect_pc_i;
   logic        halt_i;
   logic [31:0] im_ir_i;
   logic [31:0] im_pc_o;
   logic        im_readen_o;
   logic [31:0] ifid_ir_o;
   logic [31:0] ifid_pc4_o;
   logic        ifid_valid_o;
   logic        halted_o;

   modport slave (
      input  stall_i, redirect_i, redirect_pc_i, halt_i, im_ir_i,
      output im_pc_o, im_readen_o, ifid_ir_o, ifid_pc4_o, ifid_valid_o, halted_o
   );

   modport master (
      output stall_i, redirect_i, redirect_pc_i, halt_i, im_ir_i,
      input  im_pc_o, im_readen_o, ifid_ir_o, ifid_pc4_o, ifid_valid_o, halted_o
   );
endinterface

// File: rtl/if_fetch_unit.sv
// MIPS instruction-fetch stage: owns the PC, drives instruction memory and
// fills the IF/ID register; handles boot, stall, redirect and halt.
module if_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned IM_BYTES = 1024,
   parameter logic [31:0] BUBBLE   = 32'hFC00_0000
) (
   input logic            clk,
   input logic            rst_n,
   if_fetch_unit_if.slave bus
);

   typedef enum logic [1:0] {StBoot, StRun, StHalt} state_e;

   localparam logic [31:0] LastFetch = 32'(IM_BYTES - 4);

   state_e      r_state;
   state_e      w_state_d;
   logic [31:0] r_pc;
   logic [31:0] w_pc_d;
   logic [31:0] r_ir;
   logic [31:0] w_ir_d;
   logic [31:0] r_pc4;
   logic [31:0] w_pc4_d;
   logic        r_valid;
   logic        w_valid_d;
   logic        w_oor;
   logic [31:0] w_pc_plus4;

   assign w_oor      = (r_pc > LastFetch);
   assign w_pc_plus4 = r_pc + 32'd4;

   assign bus.im_pc_o      = r_pc;
   assign bus.im_readen_o  = (r_state != StRun) | w_oor;
   assign bus.ifid_ir_o    = r_ir;
   assign bus.ifid_pc4_o   = r_pc4;
   assign bus.ifid_valid_o = r_valid;
   assign bus.halted_o     = (r_state == StHalt);

   always_comb begin
      w_state_d = r_state;
      w_pc_d    = r_pc;
      w_ir_d    = r_ir;
      w_pc4_d   = r_pc4;
      w_valid_d = r_valid;
      unique case (r_state)
         StBoot: begin
            w_state_d = StRun;
            w_ir_d    = BUBBLE;
            w_pc4_d   = '0;
            w_valid_d = 1'b0;
         end
         StRun: begin
            if (bus.halt_i) begin
               w_state_d = StHalt;
               w_ir_d    = BUBBLE;
               w_pc4_d   = '0;
               w_valid_d = 1'b0;
            end else if (bus.redirect_i) begin
               w_pc_d    = bus.redirect_pc_i & 32'hFFFF_FFFC;
               w_ir_d    = BUBBLE;
               w_pc4_d   = '0;
               w_valid_d = 1'b0;
            end else if (bus.stall_i) begin
               // IF/ID holds, but an out-of-range PC still ends the run.
               if (w_oor) w_state_d = StHalt;
            end else if (w_oor) begin
               w_state_d = StHalt;
               w_ir_d    = BUBBLE;
               w_pc4_d   = '0;
               w_valid_d = 1'b0;
            end else begin
               w_pc_d    = w_pc_plus4;
               w_ir_d    = bus.im_ir_i;
               w_pc4_d   = w_pc_plus4;
               w_valid_d = 1'b1;
            end
         end
         default: begin
            w_ir_d    = BUBBLE;
            w_pc4_d   = '0;
            w_valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= StBoot;
         r_pc    <= RESET_PC;
         r_ir    <= BUBBLE;
         r_pc4   <= '0;
         r_valid <= 1'b0;
      end else begin
         r_state <= w_state_d;
         r_pc    <= w_pc_d;
         r_ir    <= w_ir_d;
         r_pc4   <= w_pc4_d;
         r_valid <= w_valid_d;
      end
   end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed scenarios with literal expectations, then
// randomized control traffic checked every cycle against a behavioural model.
module tb_if_fetch_unit;

   localparam logic [31:0] BUBBLE = 32'hFC00_0000;
   localparam int          MEM_N  = 1024;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   if_fetch_unit_if bus ();

   if_fetch_unit dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   logic [7:0] mem [MEM_N];

   function automatic logic [31:0] word_at(input logic [31:0] a);
      if (a > 32'(MEM_N - 4)) return BUBBLE;
      return {mem[a[9:0]], mem[a[9:0] + 10'd1], mem[a[9:0] + 10'd2], mem[a[9:0] + 10'd3]};
   endfunction

   assign bus.im_ir_i = bus.im_readen_o ? BUBBLE : word_at(bus.im_pc_o);

   // Model: mode 0 = booting, 1 = fetching, 2 = halted.
   int          m_mode;
   logic [31:0] m_pc, m_ir, m_pc4;
   logic        m_valid;
   int          checks   = 0;
   int          failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic m_bubble();
      m_ir = BUBBLE; m_pc4 = 32'd0; m_valid = 1'b0;
   endtask

   task automatic model_edge();
      logic oor;
      oor = (m_pc > 32'(MEM_N - 4));
      if (!rst_n) begin
         m_pc = 32'd0; m_mode = 0; m_bubble();
      end else if (m_mode == 0) begin
         m_mode = 1; m_bubble();
      end else if (m_mode == 2) begin
         m_bubble();
      end else if (bus.halt_i) begin
         m_mode = 2; m_bubble();
      end else if (bus.redirect_i) begin
         m_pc = {bus.redirect_pc_i[31:2], 2'b00}; m_bubble();
      end else if (bus.stall_i) begin
         if (oor) m_mode = 2;
      end else if (oor) begin
         m_mode = 2; m_bubble();
      end else begin
         m_ir = word_at(m_pc); m_pc4 = m_pc + 32'd4; m_valid = 1'b1; m_pc = m_pc + 32'd4;
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      model_edge();
      #1;
      check("pc", bus.im_pc_o, m_pc);
      check("readen", 32'(bus.im_readen_o), 32'((m_mode != 1) || (m_pc > 32'(MEM_N - 4))));
      check("ifid_ir", bus.ifid_ir_o, m_ir);
      check("ifid_pc4", bus.ifid_pc4_o, m_pc4);
      check("ifid_valid", 32'(bus.ifid_valid_o), 32'(m_valid));
      check("halted", 32'(bus.halted_o), 32'(m_mode == 2));
   endtask

   task automatic drive(input logic st, input logic rd, input logic [31:0] rpc, input logic ht);
      bus.stall_i = st; bus.redirect_i = rd; bus.redirect_pc_i = rpc; bus.halt_i = ht;
   endtask

   initial begin
      for (int i = 0; i < MEM_N; i++) mem[i] = 8'($urandom);
      {mem[0], mem[1], mem[2], mem[3]}             = 32'h1122_3344;
      {mem[16], mem[17], mem[18], mem[19]}         = 32'hAABB_CCDD;
      {mem[1020], mem[1021], mem[1022], mem[1023]} = 32'h0102_0304;
      m_mode = 0; m_pc = 32'd0; m_bubble();
      drive(1'b0, 1'b0, 32'd0, 1'b0);
      rst_n = 1'b0;

      // Boot
      cycle(); cycle();
      check("rst_pc", bus.im_pc_o, 32'd0);
      check("boot_readen", 32'(bus.im_readen_o), 32'd1);
      check("rst_valid", 32'(bus.ifid_valid_o), 32'd0);
      rst_n = 1'b1;
      cycle();
      check("run_readen", 32'(bus.im_readen_o), 32'd0);
      cycle();
      check("first_ir", bus.ifid_ir_o, 32'h1122_3344);
      check("first_pc4", bus.ifid_pc4_o, 32'd4);
      check("first_valid", 32'(bus.ifid_valid_o), 32'd1);
      cycle();
      check("pc_8", bus.im_pc_o, 32'd8);

      // Stall holds PC and IF/ID
      drive(1'b1, 1'b0, 32'd0, 1'b0);
      cycle(); cycle();
      check("stall_pc", bus.im_pc_o, 32'd8);
      check("stall_pc4", bus.ifid_pc4_o, 32'd8);
      drive(1'b0, 1'b0, 32'd0, 1'b0);
      cycle();
      check("unstall_pc4", bus.ifid_pc4_o, 32'd12);

      // Redirect beats stall; low address bits dropped
      drive(1'b1, 1'b1, 32'h13, 1'b0);
      cycle();
      check("redir_pc", bus.im_pc_o, 32'h10);
      check("redir_ir", bus.ifid_ir_o, BUBBLE);
      check("redir_valid", 32'(bus.ifid_valid_o), 32'd0);
      drive(1'b0, 1'b0, 32'd0, 1'b0);
      cycle();
      check("redir_fetch", bus.ifid_ir_o, 32'hAABB_CCDD);

      // Last legal word, then out-of-range halt
      drive(1'b0, 1'b1, 32'h3FC, 1'b0);
      cycle();
      drive(1'b0, 1'b0, 32'd0, 1'b0);
      cycle();
      check("last_ir", bus.ifid_ir_o, 32'h0102_0304);
      check("last_valid", 32'(bus.ifid_valid_o), 32'd1);
      check("oor_pc", bus.im_pc_o, 32'h400);
      check("oor_readen", 32'(bus.im_readen_o), 32'd1);
      cycle();
      check("oor_halted", 32'(bus.halted_o), 32'd1);
      check("oor_valid", 32'(bus.ifid_valid_o), 32'd0);

      // Reset out of HALT, then halt beats redirect
      rst_n = 1'b0;
      cycle();
      check("halt_rst_pc", bus.im_pc_o, 32'd0);
      check("halt_rst_halted", 32'(bus.halted_o), 32'd0);
      rst_n = 1'b1;
      cycle(); cycle(); cycle();
      drive(1'b0, 1'b1, 32'h40, 1'b1);
      cycle();
      check("halt_pc", bus.im_pc_o, 32'd8);
      check("halt_halted", 32'(bus.halted_o), 32'd1);
      drive(1'b1, 1'b1, 32'h80, 1'b0);
      cycle(); cycle();
      check("halt_frozen_pc", bus.im_pc_o, 32'd8);
      check("halt_frozen_readen", 32'(bus.im_readen_o), 32'd1);

      // Reset during a stall
      drive(1'b0, 1'b0, 32'd0, 1'b0);
      rst_n = 1'b0;
      cycle();
      rst_n = 1'b1;
      cycle(); cycle(); cycle();
      drive(1'b1, 1'b0, 32'd0, 1'b0);
      cycle();
      rst_n = 1'b0;
      cycle();
      check("stall_rst_pc", bus.im_pc_o, 32'd0);
      check("stall_rst_valid", 32'(bus.ifid_valid_o), 32'd0);
      rst_n = 1'b1;

      // Randomized control traffic
      for (int n = 0; n < 4000; n++) begin
         rst_n = ($urandom_range(0, 149) != 0);
         drive($urandom_range(0, 4) == 0, $urandom_range(0, 11) == 0,
               32'($urandom_range(0, 1100)), $urandom_range(0, 399) == 0);
         cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
